// File: rtl/dual_stream_generator.sv
// Emits two STREAM_LENGTH-bit unary streams (A and B) for the histogram compressor.
// Each stream is in thermometer or bit-reversed order, with a programmable number of ones.
module dual_stream_generator #(
    parameter int STREAM_LENGTH = 128,
    parameter int COUNTER_WIDTH = $clog2(STREAM_LENGTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [COUNTER_WIDTH-1:0] value_a,
    input  logic [COUNTER_WIDTH-1:0] value_b,
    input  logic                     mode_a,
    input  logic                     mode_b,
    input  logic                     pause,
    output logic                     stream_a,
    output logic                     stream_b,
    output logic                     valid_out,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = $clog2(STREAM_LENGTH);
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(STREAM_LENGTH - 1);
    localparam logic [COUNTER_WIDTH-1:0] MAX_VAL  = COUNTER_WIDTH'(STREAM_LENGTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state, state_next;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         idx_inc;
    logic [COUNTER_WIDTH-1:0] val_a_q, val_b_q;
    logic                     mode_a_q, mode_b_q;
    logic [COUNTER_WIDTH-1:0] sat_a, sat_b;
    logic                     accept, emit, finish;

    function automatic logic gen_bit(input logic [IDX_W-1:0] i,
                                     input logic [COUNTER_WIDTH-1:0] v,
                                     input logic m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < IDX_W; k++)
            r[k] = i[IDX_W-1-k];
        return COUNTER_WIDTH'(m ? r : i) < v;
    endfunction

    always_comb begin
        sat_a   = (value_a > MAX_VAL) ? MAX_VAL : value_a;
        sat_b   = (value_b > MAX_VAL) ? MAX_VAL : value_b;
        idx_inc = idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // idx names the bit currently presented on the outputs, so reaching
    // LAST_IDX in RUN means the final bit has already been shown once.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        emit       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept     = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else if (!pause) begin
                    emit = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            val_a_q   <= '0;
            val_b_q   <= '0;
            mode_a_q  <= 1'b0;
            mode_b_q  <= 1'b0;
            stream_a  <= 1'b0;
            stream_b  <= 1'b0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            done      <= 1'b0;
            if (accept) begin
                val_a_q   <= sat_a;
                val_b_q   <= sat_b;
                mode_a_q  <= mode_a;
                mode_b_q  <= mode_b;
                idx       <= '0;
                stream_a  <= gen_bit('0, sat_a, mode_a);
                stream_b  <= gen_bit('0, sat_b, mode_b);
                valid_out <= 1'b1;
                busy      <= 1'b1;
            end else if (emit) begin
                idx       <= idx_inc;
                stream_a  <= gen_bit(idx_inc, val_a_q, mode_a_q);
                stream_b  <= gen_bit(idx_inc, val_b_q, mode_b_q);
                valid_out <= 1'b1;
            end else if (finish) begin
                idx      <= '0;
                stream_a <= 1'b0;
                stream_b <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: doc/dual_stream_generator.md
DUAL_STREAM_GENERATOR -- requirements
Module: dual_stream_generator

Interface
REQ-001 SHALL have parameter STREAM_LENGTH, default 128, giving bits per stream; it is a power of two, at least 2.
REQ-002 SHALL have parameter COUNTER_WIDTH, default $clog2(STREAM_LENGTH+1), giving the width of the value inputs.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, a request to generate one stream pair.
REQ-006 SHALL have port value_a, input, COUNTER_WIDTH bits, the number of ones in stream A.
REQ-007 SHALL have port value_b, input, COUNTER_WIDTH bits, the number of ones in stream B.
REQ-008 SHALL have port mode_a, input, 1 bit, the bit ordering of stream A: 0 = thermometer, 1 = bit-reversed.
REQ-009 SHALL have port mode_b, input, 1 bit, the bit ordering of stream B, encoded as mode_a.
REQ-010 SHALL have port pause, input, 1 bit, which stalls emission while high.
REQ-011 SHALL have port stream_a, output, 1 bit, registered; it feeds the histogram compressor stream_a.
REQ-012 SHALL have port stream_b, output, 1 bit, registered; it feeds the histogram compressor stream_b.
REQ-013 SHALL have port valid_out, output, 1 bit, registered; it feeds the histogram compressor valid_in.
REQ-014 SHALL have port busy, output, 1 bit, registered; it is high while a stream pair is in progress.
REQ-015 SHALL have port done, output, 1 bit, registered; it is a one-cycle completion pulse.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE.
- IDLE→RUN on start=1.
- RUN→DONE when the last bit is emitted.
- DONE→IDLE unconditionally after 1 cycle.
REQ-017 SHALL accept start only in IDLE.
- start in RUN or DONE is ignored; it is not queued.
REQ-018 SHALL latch value_a, value_b, mode_a and mode_b on the accepting edge.
- Input changes after acceptance have no effect on the current pair.
REQ-019 SHALL saturate a latched value greater than STREAM_LENGTH to STREAM_LENGTH.
REQ-020 SHALL keep a bit index idx of width log2(STREAM_LENGTH).
- idx starts at 0 and advances by 1 per emitted bit.
- idx does not wrap within a run.
REQ-021 SHALL generate stream bits as follows.
- Thermometer mode: bit = (idx < value).
- Bit-reversed mode: bit = (bitreverse(idx) < value).
- Both orderings give exactly value ones per STREAM_LENGTH bits.
REQ-022 SHALL emit index 0 in the cycle immediately after the accepting edge (latency 1 cycle).
- In each RUN cycle with pause=0, the bit pair for the current idx is presented with valid_out=1.
REQ-023 SHALL behave as follows during RUN with pause=1.
- valid_out=0.
- idx holds.
- stream_a and stream_b hold their last value.
- No bit is skipped or repeated.
REQ-024 SHALL keep valid_out=0 in IDLE and DONE.
- Exactly STREAM_LENGTH valid cycles occur per accepted start.
REQ-025 SHALL hold busy=1 from the cycle after acceptance through the cycle carrying the last valid bit, including paused cycles.
REQ-026 SHALL pulse done=1 for exactly one cycle, the cycle after the last valid bit.
- busy=0 in that cycle.
REQ-027 SHALL accept a new start in the cycle after done at the earliest (back-to-back spacing STREAM_LENGTH+2 cycles, no pause).
REQ-028 SHALL ignore pause in IDLE and DONE.

Reset
REQ-029 SHALL, while rst=1, asynchronously force state=IDLE and idx=0.
- Outputs stream_a, stream_b, valid_out, busy and done = 0.
- Latched values and modes = 0.
REQ-030 SHALL abort a run when reset is asserted mid-RUN.
- No done pulse is produced.
- After rst falls, the block waits in IDLE for a fresh start.

Verification (STREAM_LENGTH=128; downstream histogram counts shown as 00/01/10/11)
REQ-031 SHALL cover: value_a=0, value_b=128, both modes 0, start pulse → 128 valid cycles, A all 0, B all 1, done 129 cycles after the accept edge; counts 0/128/0/0.
REQ-032 SHALL cover: value_a=64 mode_a=0, value_b=64 mode_b=1 → A=1 for idx 0..63, B=1 on even idx; counts 32/32/32/32.
REQ-033 SHALL cover: value_a=200, value_b=255 → both saturate to 128; counts 0/0/0/128.
REQ-034 SHALL cover: pause held high for 10 cycles starting at idx 40 → still exactly 128 valid bits in order; done 139 cycles after the accept edge; busy high throughout the pause.
REQ-035 SHALL cover: start re-asserted at idx 20 → ignored, the single run completes unchanged. rst pulsed at idx 50 → all outputs 0 immediately, no done pulse; a subsequent start runs a full, correct 128-bit pair.
